// File: rtl/rv32_mc_ctrl_if.sv
// Memory request bus between the multi-cycle controller (master) and the memory port (slave).
interface rv32_mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT, datapath strobes and retire counter.
module rv32_mc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          instr,
    input  logic                 branch_taken,
    rv32_mc_ctrl_if.master       mem,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 pc_src,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output logic [2:0]           imm_sel,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 retire,
    output logic [31:0]          instret,
    output logic                 illegal
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
    typedef enum logic [3:0] {
        OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_BAD
    } op_e;

    // RESET_PC is consumed by the external PC register; the immediate fields are decoded elsewhere.
    localparam logic unused_reset_pc = ^RESET_PC;
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[31:7];

    function automatic op_e decode(input logic [6:0] opc);
        case (opc)
            7'b0110011: return OP_R;
            7'b0010011: return OP_I;
            7'b0000011: return OP_LOAD;
            7'b0100011: return OP_STORE;
            7'b1100011: return OP_BRANCH;
            7'b1101111: return OP_JAL;
            7'b1100111: return OP_JALR;
            7'b0110111: return OP_LUI;
            7'b0010111: return OP_AUIPC;
            default:    return OP_BAD;
        endcase
    endfunction

    state_e state, nxt;
    op_e    op, opn;
    logic   br_q, pc_we_q, retire_q, wb_pc_src, st_done, jump_n;

    always_comb begin
        case (instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: imm_sel = 3'd0;
            7'b0100011:                         imm_sel = 3'd1;
            7'b1100011:                         imm_sel = 3'd2;
            7'b0110111, 7'b0010111:             imm_sel = 3'd3;
            7'b1101111:                         imm_sel = 3'd4;
            default:                            imm_sel = 3'd0;
        endcase
    end

    // The opcode class is latched only on the DECODE edge; later instr changes are ignored.
    always_comb begin
        opn = (state == S_DECODE) ? decode(instr[6:0]) : op;
        nxt = state;
        case (state)
            S_FETCH:  if (mem.mem_req && mem.mem_ready) nxt = S_DECODE;
            S_DECODE: nxt = (opn == OP_BAD) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (op)
                    OP_LOAD, OP_STORE: nxt = S_MEM;
                    OP_BRANCH:         nxt = S_FETCH;
                    default:           nxt = S_WB;
                endcase
            end
            S_MEM:    if (mem.mem_ready) nxt = (op == OP_LOAD) ? S_WB : S_FETCH;
            S_WB:     nxt = S_FETCH;
            default:  nxt = S_HALT;
        endcase
    end

    assign jump_n = (opn == OP_JAL) || (opn == OP_JALR);

    // NOTE: ir_we, store completion and branch pc_src must answer mem_ready/branch_taken in the
    // same cycle, so they are combinational terms layered on the registered state outputs.
    assign st_done = (state == S_MEM) && mem.mem_we && mem.mem_ready;
    assign ir_we   = (state == S_FETCH) && mem.mem_req && mem.mem_ready;
    assign pc_we   = pc_we_q || st_done;
    assign retire  = retire_q || st_done;
    assign pc_src  = wb_pc_src || (br_q && branch_taken);

    // Registered outputs are derived from the state being entered, so they are valid all of it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_FETCH;
            op           <= OP_R;
            mem.mem_req  <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.addr_sel <= 1'b0;
            alu_a_sel    <= 1'b0;
            alu_b_sel    <= 1'b0;
            br_q         <= 1'b0;
            reg_we       <= 1'b0;
            wb_sel       <= 2'd0;
            wb_pc_src    <= 1'b0;
            pc_we_q      <= 1'b0;
            retire_q     <= 1'b0;
            illegal      <= 1'b0;
            instret      <= 32'd0;
        end else begin
            state        <= nxt;
            op           <= opn;
            mem.mem_req  <= (nxt == S_FETCH) || (nxt == S_MEM);
            mem.mem_we   <= (nxt == S_MEM) && (opn == OP_STORE);
            mem.addr_sel <= (nxt == S_MEM);
            alu_a_sel    <= (nxt == S_EXEC) && (opn inside {OP_BRANCH, OP_JAL, OP_AUIPC});
            alu_b_sel    <= (nxt == S_EXEC) && (opn != OP_R);
            br_q         <= (nxt == S_EXEC) && (opn == OP_BRANCH);
            reg_we       <= (nxt == S_WB);
            wb_sel       <= (nxt != S_WB) ? 2'd0 : (opn == OP_LOAD) ? 2'd1 : jump_n ? 2'd2 : 2'd0;
            wb_pc_src    <= (nxt == S_WB) && jump_n;
            pc_we_q      <= (nxt == S_WB) || ((nxt == S_EXEC) && (opn == OP_BRANCH));
            retire_q     <= (nxt == S_WB) || ((nxt == S_EXEC) && (opn == OP_BRANCH));
            illegal      <= illegal || (nxt == S_HALT);
            if (retire) instret <= instret + 32'd1;
        end
    end

endmodule
